jump_redirect_ctrl: RTL and testbench
=====================================

JUMP_REDIRECT_CTRL -- requirements
Module: jump_redirect_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath/address width.
REQ-002 Parameter CNT_W, default 16, width of the redirect performance counter.
REQ-003 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 jump_valid  in  1  execute stage offers a resolved jal/jalr.
REQ-007 jump_target  in  XLEN  computed target (pc + jimm20 or rs1 + imm).
REQ-008 jump_link  in  XLEN  link value (pc + 4).
REQ-009 jump_rd  in  5  destination register index.
REQ-010 jump_ready  out  1  controller can accept a jump this cycle.
REQ-011 trap_valid  in  1  trap request from the exception unit.
REQ-012 trap_vector  in  XLEN  trap handler address.
REQ-013 trap_ready  out  1  controller can accept a trap this cycle.
REQ-014 flush  out  1  one-cycle kill of fetch/decode contents.
REQ-015 redirect_valid / redirect_pc  out  1 / XLEN  new PC offered to fetch.
REQ-016 fetch_ready  in  1  fetch accepts the redirect.
REQ-017 wb_valid / wb_rd / wb_value  out  1 / 5 / XLEN  link write to the register file.
REQ-018 wb_ready  in  1  register file accepts the write.
REQ-019 misaligned_exc / misaligned_addr  out  1 / XLEN  target-misaligned exception pulse and faulting target.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 redirect_count  out  CNT_W  number of completed redirects.

Function
REQ-022 FSM states SHALL be IDLE, FLUSH, REDIRECT, WRITEBACK and EXC; all control outputs are Moore-decoded from the state.
REQ-023 jump_ready and trap_ready SHALL be 1 only in IDLE.
REQ-024 In IDLE, trap_valid SHALL win over a simultaneous jump_valid; the trap is captured and jump_ready is driven 0 in that cycle.
REQ-025 Trap acceptance SHALL capture trap_vector as the target, mark no-writeback, and go to FLUSH.
REQ-026 Jump acceptance (jump_valid & jump_ready & !trap_valid) SHALL capture target, link and rd.
REQ-027 After jump acceptance, the next state SHALL be EXC if jump_target[1:0] != 0, else FLUSH.
REQ-028 jalr bit-0 clearing SHALL be done by the producer; the controller tests both low bits.
REQ-029 FLUSH SHALL assert flush for exactly one cycle, then go to REDIRECT.
REQ-030 REDIRECT SHALL hold redirect_valid=1 and redirect_pc stable until fetch_ready=1.
REQ-031 On the handshake cycle, redirect_count SHALL increment by 1, wrapping from all-ones to 0.
REQ-032 After the handshake, the next state SHALL be WRITEBACK for a jump with rd != 0, else IDLE; rd == 0 and traps never assert wb_valid.
REQ-033 WRITEBACK SHALL hold wb_valid=1 with stable wb_rd/wb_value until wb_ready=1, then go to IDLE.
REQ-034 EXC SHALL assert misaligned_exc for one cycle with misaligned_addr = captured target, with no flush, no redirect, no writeback and no count change, then go to IDLE.
REQ-035 Minimum latency, acceptance to redirect_valid, SHALL be 2 cycles; a full jal with an immediate fetch_ready and wb_ready SHALL return to IDLE 4 cycles after acceptance.
REQ-036 trap_valid or jump_valid outside IDLE SHALL be ignored; requesters hold their request until ready.

Reset
REQ-037 On reset=1 the state SHALL become IDLE and redirect_count 0.
REQ-038 On reset=1 all captured registers and redirect_pc, wb_rd, wb_value and misaligned_addr SHALL become 0.
REQ-039 On reset=1 flush, redirect_valid, wb_valid, misaligned_exc and busy SHALL become 0.
REQ-040 Reset asserted mid-sequence SHALL abandon the sequence with no further redirect or writeback.

Structure
REQ-041 The FSM state encoding and the alignment mask constant (2'b11) SHALL live in the shared rv package.
REQ-042 A single flat module SHALL be used; no sub-module is warranted.

Verification
REQ-043 jal, target 0x0000_1000, link 0x0000_0FFC, rd=1, fetch_ready and wb_ready tied 1 -> flush at T+1, redirect_pc 0x1000 at T+2, wb x1=0x0FFC at T+3, count=1.
REQ-044 Jump with rd=0 -> redirect only, wb_valid never asserted, return to IDLE after the handshake.
REQ-045 Target 0x0000_1002 -> misaligned_exc one cycle with addr 0x1002, flush=0, count unchanged.
REQ-046 trap_valid and jump_valid in the same cycle, vector 0x0000_0100 -> redirect_pc 0x100, no wb, jump_ready=0 that cycle.
REQ-047 fetch_ready held 0 for 5 cycles -> redirect_valid and redirect_pc stable throughout; same for wb_ready with wb_valid.
REQ-048 Reset pulse in REDIRECT -> next cycle IDLE, all outputs 0; count at all-ones plus one redirect -> 0.

Source files
------------

// File: rtl/jump_redirect_ctrl_pkg.sv
// Shared definitions for the jump/trap redirect controller: FSM encoding,
// alignment mask and the target alignment test.
package jump_redirect_ctrl_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_FLUSH     = 3'd1;
  localparam logic [STATE_W-1:0] ST_REDIRECT  = 3'd2;
  localparam logic [STATE_W-1:0] ST_WRITEBACK = 3'd3;
  localparam logic [STATE_W-1:0] ST_EXC       = 3'd4;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Both low bits are tested; jalr bit-0 clearing is the producer's job.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return |(addr_lo & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/jump_redirect_ctrl.sv
// Sequences a resolved jump or trap into flush, fetch redirect and link
// writeback, raising a misaligned-target exception instead when required.
module jump_redirect_ctrl
  import jump_redirect_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 jump_valid,
  input  logic [XLEN-1:0]      jump_target,
  input  logic [XLEN-1:0]      jump_link,
  input  logic [REG_IDX_W-1:0] jump_rd,
  output logic                 jump_ready,
  input  logic                 trap_valid,
  input  logic [XLEN-1:0]      trap_vector,
  output logic                 trap_ready,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  input  logic                 fetch_ready,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_value,
  input  logic                 wb_ready,
  output logic                 misaligned_exc,
  output logic [XLEN-1:0]      misaligned_addr,
  output logic                 busy,
  output logic [CNT_W-1:0]     redirect_count
);

  logic [STATE_W-1:0]   state_q,  state_d;
  logic [XLEN-1:0]      target_q, target_d;
  logic [XLEN-1:0]      link_q,   link_d;
  logic [REG_IDX_W-1:0] rd_q,     rd_d;
  logic                 no_wb_q,  no_wb_d;
  logic [CNT_W-1:0]     count_q,  count_d;

  logic flush_q,    flush_d;
  logic redir_q,    redir_d;
  logic wbv_q,      wbv_d;
  logic exc_q,      exc_d;
  logic busy_q,     busy_d;

  // Next-state, capture and counter logic.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    link_d   = link_q;
    rd_d     = rd_q;
    no_wb_d  = no_wb_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (trap_valid) begin
          target_d = trap_vector;
          rd_d     = '0;
          no_wb_d  = 1'b1;
          state_d  = ST_FLUSH;
        end else if (jump_valid) begin
          target_d = jump_target;
          link_d   = jump_link;
          rd_d     = jump_rd;
          no_wb_d  = (jump_rd == '0);
          state_d  = is_misaligned(jump_target[1:0]) ? ST_EXC : ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_REDIRECT;
      ST_REDIRECT: begin
        if (fetch_ready) begin
          count_d = count_q + CNT_W'(1);
          state_d = no_wb_q ? ST_IDLE : ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        if (wb_ready) state_d = ST_IDLE;
      end
      ST_EXC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs registered from the upcoming state so they align with it.
  always_comb begin
    flush_d = (state_d == ST_FLUSH);
    redir_d = (state_d == ST_REDIRECT);
    wbv_d   = (state_d == ST_WRITEBACK);
    exc_d   = (state_d == ST_EXC);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      link_q   <= '0;
      rd_q     <= '0;
      no_wb_q  <= 1'b0;
      count_q  <= '0;
      flush_q  <= 1'b0;
      redir_q  <= 1'b0;
      wbv_q    <= 1'b0;
      exc_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      link_q   <= link_d;
      rd_q     <= rd_d;
      no_wb_q  <= no_wb_d;
      count_q  <= count_d;
      flush_q  <= flush_d;
      redir_q  <= redir_d;
      wbv_q    <= wbv_d;
      exc_q    <= exc_d;
      busy_q   <= busy_d;
    end
  end

  // A trap in IDLE pre-empts a simultaneous jump, so jump_ready drops that cycle.
  assign trap_ready      = (state_q == ST_IDLE);
  assign jump_ready      = (state_q == ST_IDLE) & ~trap_valid;
  assign flush           = flush_q;
  assign redirect_valid  = redir_q;
  assign redirect_pc     = target_q;
  assign wb_valid        = wbv_q;
  assign wb_rd           = rd_q;
  assign wb_value        = link_q;
  assign misaligned_exc  = exc_q;
  assign misaligned_addr = target_q;
  assign busy            = busy_q;
  assign redirect_count  = count_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl with a scoreboard of expected
// redirects, link writebacks and misaligned exceptions.
module tb_jump_redirect_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             jump_valid;
  logic [XLEN-1:0]  jump_target;
  logic [XLEN-1:0]  jump_link;
  logic [4:0]       jump_rd;
  logic             jump_ready;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_vector;
  logic             trap_ready;
  logic             flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             fetch_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_value;
  logic             wb_ready;
  logic             misaligned_exc;
  logic [XLEN-1:0]  misaligned_addr;
  logic             busy;
  logic [CNT_W-1:0] redirect_count;

  int vectors    = 0;
  int miscompares = 0;

  logic [XLEN-1:0] exp_redir[$];
  logic [36:0]     exp_wb[$];
  logic [XLEN-1:0] exp_exc[$];

  jump_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .jump_valid(jump_valid), .jump_target(jump_target), .jump_link(jump_link),
    .jump_rd(jump_rd), .jump_ready(jump_ready),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .trap_ready(trap_ready),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_ready(fetch_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_value(wb_value), .wb_ready(wb_ready), .misaligned_exc(misaligned_exc),
    .misaligned_addr(misaligned_addr), .busy(busy), .redirect_count(redirect_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic issue_jump(input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] lnk,
                            input logic [4:0] rd);
    jump_valid  = 1'b1;
    jump_target = tgt;
    jump_link   = lnk;
    jump_rd     = rd;
    #1;
    chk("jump_ready_idle", jump_ready, 1);
    step();
    jump_valid = 1'b0;
  endtask

  // Scoreboard: every handshake or exception pulse must match the queue head.
  always @(negedge clock) begin
    if (!reset) begin
      if (redirect_valid && fetch_ready) begin
        if (exp_redir.size() == 0) chk("unexpected_redirect", redirect_valid, 0);
        else chk("sb_redirect_pc", redirect_pc, exp_redir.pop_front());
      end
      if (wb_valid && wb_ready) begin
        if (exp_wb.size() == 0) chk("unexpected_wb", wb_valid, 0);
        else chk("sb_wb", {wb_rd, wb_value}, exp_wb.pop_front());
      end
      if (misaligned_exc) begin
        if (exp_exc.size() == 0) chk("unexpected_exc", misaligned_exc, 0);
        else chk("sb_exc_addr", misaligned_addr, exp_exc.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; jump_valid = 1'b0; jump_target = '0; jump_link = '0; jump_rd = '0;
    trap_valid = 1'b0; trap_vector = '0; fetch_ready = 1'b1; wb_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_wb", wb_valid, 0);
    chk("rst_exc", misaligned_exc, 0);
    chk("rst_count", redirect_count, 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_trap_ready", trap_ready, 1);

    // jal x1, full sequence with immediate handshakes
    exp_redir.push_back(32'h0000_1000);
    exp_wb.push_back({5'd1, 32'h0000_0FFC});
    issue_jump(32'h0000_1000, 32'h0000_0FFC, 5'd1);
    chk("jal_t1_flush", flush, 1);
    chk("jal_t1_busy", busy, 1);
    chk("jal_t1_redir", redirect_valid, 0);
    step();
    chk("jal_t2_redir", redirect_valid, 1);
    chk("jal_t2_pc", redirect_pc, 32'h0000_1000);
    chk("jal_t2_flush", flush, 0);
    step();
    chk("jal_t3_wb", wb_valid, 1);
    chk("jal_t3_rd", wb_rd, 1);
    chk("jal_t3_val", wb_value, 32'h0000_0FFC);
    chk("jal_t3_count", redirect_count, 1);
    step();
    chk("jal_t4_busy", busy, 0);
    chk("jal_t4_wb", wb_valid, 0);

    // rd = 0: redirect only
    exp_redir.push_back(32'h0000_2000);
    issue_jump(32'h0000_2000, 32'h0000_2004, 5'd0);
    step();
    chk("rd0_redir", redirect_valid, 1);
    step();
    chk("rd0_idle", busy, 0);
    chk("rd0_nowb", wb_valid, 0);
    chk("rd0_count", redirect_count, 2);

    // misaligned target
    exp_exc.push_back(32'h0000_1002);
    issue_jump(32'h0000_1002, 32'h0000_0FFC, 5'd1);
    chk("mis_exc", misaligned_exc, 1);
    chk("mis_addr", misaligned_addr, 32'h0000_1002);
    chk("mis_flush", flush, 0);
    chk("mis_redir", redirect_valid, 0);
    step();
    chk("mis_exc_off", misaligned_exc, 0);
    chk("mis_idle", busy, 0);
    chk("mis_count", redirect_count, 2);
    chk("mis_nowb", wb_valid, 0);

    // trap wins over simultaneous jump
    exp_redir.push_back(32'h0000_0100);
    trap_valid = 1'b1; trap_vector = 32'h0000_0100;
    jump_valid = 1'b1; jump_target = 32'h0000_3000; jump_link = 32'h0000_2FFC; jump_rd = 5'd5;
    #1;
    chk("trap_jump_ready", jump_ready, 0);
    chk("trap_trap_ready", trap_ready, 1);
    step();
    trap_valid = 1'b0; jump_valid = 1'b0;
    chk("trap_flush", flush, 1);
    step();
    chk("trap_pc", redirect_pc, 32'h0000_0100);
    step();
    chk("trap_idle", busy, 0);
    chk("trap_nowb", wb_valid, 0);
    chk("trap_count", redirect_count, 3);

    // back-pressure on fetch and writeback; requests during stall ignored
    fetch_ready = 1'b0; wb_ready = 1'b0;
    exp_redir.push_back(32'h0000_4000);
    exp_wb.push_back({5'd7, 32'h0000_3FFC});
    issue_jump(32'h0000_4000, 32'h0000_3FFC, 5'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        jump_valid = 1'b1; jump_target = 32'h0000_9000; jump_rd = 5'd9;
        trap_valid = 1'b1; trap_vector = 32'h0000_0200;
        #1;
        chk("stall_trap_ready", trap_ready, 0);
        chk("stall_jump_ready", jump_ready, 0);
      end
      if (i == 2) begin
        jump_valid = 1'b0; trap_valid = 1'b0;
      end
      chk("stall_redir", redirect_valid, 1);
      chk("stall_pc", redirect_pc, 32'h0000_4000);
    end
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("wbstall_valid", wb_valid, 1);
      chk("wbstall_rd", wb_rd, 7);
      chk("wbstall_val", wb_value, 32'h0000_3FFC);
      step();
    end
    wb_ready = 1'b1;
    step();
    chk("stall_idle", busy, 0);
    chk("stall_count", redirect_count, 4);

    // reset in REDIRECT abandons the sequence
    issue_jump(32'h0000_5000, 32'h0000_4FFC, 5'd3);
    step();
    chk("rstmid_redir", redirect_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    fetch_ready = 1'b1;
    chk("rstmid_redir_off", redirect_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_pc", redirect_pc, 0);
    chk("rstmid_count", redirect_count, 0);
    chk("rstmid_wb", wb_valid, 0);
    chk("rstmid_flush", flush, 0);
    repeat (3) step();
    chk("rstmid_quiet", redirect_valid, 0);
    chk("rstmid_quiet_wb", wb_valid, 0);

    // counter wrap: all-ones plus one redirect gives zero
    for (int i = 0; i < 15; i++) begin
      exp_redir.push_back(32'h0000_6000 + 32'(i * 4));
      issue_jump(32'h0000_6000 + 32'(i * 4), 32'h0, 5'd0);
      repeat (3) step();
    end
    chk("wrap_allones", redirect_count, 4'hF);
    exp_redir.push_back(32'h0000_7000);
    issue_jump(32'h0000_7000, 32'h0, 5'd0);
    repeat (3) step();
    chk("wrap_zero", redirect_count, 0);

    step();
    chk("sb_redir_drained", 64'(exp_redir.size()), 0);
    chk("sb_wb_drained", 64'(exp_wb.size()), 0);
    chk("sb_exc_drained", 64'(exp_exc.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
